// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI initiator: FSM states, command opcodes, widths.
package spi_pkg;

    localparam int WORD_W_DEF     = 10;
    localparam int RD_W_DEF       = 8;
    localparam int GAP_CYCLES_DEF = 2;
    localparam int CNT_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CMD,
        ST_SHIFT,
        ST_TURN,
        ST_READ,
        ST_DONE,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load MSB-first shift register; ser_o is the current MSB, shf_o the value after one shift.
// Load wins over shift; state changes only when load_i or shift_i is high.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_dat_i,
    input  logic         shift_i,
    input  logic         ser_i,
    output logic         ser_o,
    output logic [W-1:0] shf_o
);

    logic [W-1:0] sr_q, sr_d;

    assign ser_o = sr_q[W-1];
    assign shf_o = {sr_q[W-2:0], ser_i};

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_dat_i;
        end else if (shift_i) begin
            sr_d = shf_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/spi_master_if.sv
// SPI initiator: frames a 10b command on SS_n/MOSI (12 low cycles, 21 with an 8b MISO read), one command at a time.
// cmd_ready only in IDLE; all other outputs registered. SPI_MASTER_GAP_EN adds a GAP state holding SS_n high after DONE.
module spi_master_if
    import spi_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int RD_W   = RD_W_DEF
`ifdef SPI_MASTER_GAP_EN
    , parameter int GAP_CYCLES = GAP_CYCLES_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WORD_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [RD_W-1:0]   rsp_data,
    output logic              done,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RD_W-1:0]    rsp_data_q, rsp_data_d;
    logic               ss_n_q, mosi_q, done_q, busy_q, rsp_valid_q;
    logic               ss_n_d, mosi_d;

    logic               tx_load, tx_shift, tx_ser;
    logic [WORD_W-1:0]  tx_shf_unused;
    logic               rx_shift, rx_ser_unused;
    logic [RD_W-1:0]    rx_shf;

    spi_shift_reg #(.W(WORD_W)) u_tx_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tx_load),
        .load_dat_i (cmd_data),
        .shift_i    (tx_shift),
        .ser_i      (1'b0),
        .ser_o      (tx_ser),
        .shf_o      (tx_shf_unused)
    );

    spi_shift_reg #(.W(RD_W)) u_rx_sr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tx_load),
        .load_dat_i ('0),
        .shift_i    (rx_shift),
        .ser_i      (MISO),
        .ser_o      (rx_ser_unused),
        .shf_o      (rx_shf)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        tx_load    = 1'b0;
        rx_shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tx_load = 1'b1;
                    op_d    = op_e'(cmd_data[WORD_W-1 -: 2]);
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_CMD;
            ST_CMD: begin
                state_d = ST_SHIFT;
                cnt_d   = CNT_W'(WORD_W - 1);
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = (op_q == OP_RD_DATA) ? ST_TURN : ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_TURN: begin
                state_d = ST_READ;
                cnt_d   = CNT_W'(RD_W - 1);
            end
            ST_READ: begin
                // Sample on the edge that closes each READ cycle; the last sample lands straight in rsp_data.
                rx_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = ST_DONE;
                    rsp_data_d = rx_shf;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef SPI_MASTER_GAP_EN
            ST_DONE: begin
                state_d = ST_GAP;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`else
            ST_DONE: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        tx_shift = (state_d == ST_SHIFT);
        ss_n_d   = !(state_d inside {ST_START, ST_CMD, ST_SHIFT, ST_TURN, ST_READ});
        mosi_d   = (state_d == ST_CMD || state_d == ST_SHIFT) ? tx_ser : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WR_ADDR;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            done_q      <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
            rsp_valid_q <= (state_d == ST_DONE) && (op_q == OP_RD_DATA);
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_if.sv
// Bench for spi_master_if: directed vector table, back-to-back and reset corner cases, random frames vs. a frame-level model.
module tb_spi_master_if;

`ifdef SPI_MASTER_GAP_EN
    localparam int EXP_HIGH = 1 + 2;
`else
    localparam int EXP_HIGH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       done;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    int n_chk  = 0;
    int n_fail = 0;

    spi_master_if dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .done      (done),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          low;
        logic [31:0] seq;
        int          dones;
        int          rsps;
        int          bad;
        int          prehigh;
        logic [7:0]  rsp;
        bit          to;
    } fr_t;

    typedef struct {
        logic [9:0]  w;
        logic [7:0]  mb;
        int          low;
        logic [31:0] seq;
        int          rv;
        logic [7:0]  rsp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge. Drives one command, plays the slave on MISO, records what the bus did.
    task automatic run_frame(input logic [9:0] w, input logic [7:0] mb, input bit toggle,
                             input bit chain, input logic [9:0] nw, output fr_t r);
        bit acc = 0;
        bit fin = 0;
        bit seen_low = 0;
        r.low = 0; r.seq = '0; r.dones = 0; r.rsps = 0; r.bad = 0; r.prehigh = 0; r.rsp = '0; r.to = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        for (int c = 0; c < 80 && !fin; c++) begin
            if (cmd_valid && cmd_ready && !acc) acc = 1;
            @(negedge clk);
            if (!SS_n) begin
                r.low++;
                r.seq = {r.seq[30:0], MOSI};
                seen_low = 1;
            end else if (!seen_low) begin
                r.prehigh++;
            end
            if (done) r.dones++;
            if (rsp_valid) begin
                r.rsps++;
                if (!done) r.bad++;
            end
            if (!SS_n && r.low >= 14 && r.low <= 21) MISO = mb[7 - (r.low - 14)];
            else MISO = 1'($urandom);
            if (acc) begin
                cmd_valid = toggle ? (1'($urandom) && !done) : 1'b0;
                if (toggle) cmd_data = 10'($urandom);
            end
            if (done) begin
                fin = 1;
                r.rsp = rsp_data;
                if (chain) begin
                    cmd_data  = nw;
                    cmd_valid = 1'b1;
                end
            end
        end
        r.to = !fin;
    endtask

    // Frame-level model: START(0), CMD(w[9]), 10 word bits, then TURN + 8 READ cycles of 0 for opcode 11.
    function automatic int exp_low(input logic [9:0] w);
        return (w[9:8] == 2'b11) ? 21 : 12;
    endfunction

    function automatic logic [31:0] exp_seq(input logic [9:0] w);
        logic [31:0] s;
        s = {20'd0, 1'b0, w[9], w};
        if (w[9:8] == 2'b11) s = s << 9;
        return s;
    endfunction

    task automatic check_frame(input string tag, input fr_t r, input logic [9:0] w, input logic [7:0] rsp_exp);
        chk({tag, "_timeout"}, 32'(r.to), 0);
        chk({tag, "_low"}, r.low, exp_low(w));
        chk({tag, "_mosi"}, r.seq, exp_seq(w));
        chk({tag, "_done"}, r.dones, 1);
        chk({tag, "_rspv"}, r.rsps, (w[9:8] == 2'b11) ? 1 : 0);
        chk({tag, "_rsp_not_with_done"}, r.bad, 0);
        chk({tag, "_rsp_data"}, r.rsp, rsp_exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       vt[5];
        fr_t        r;
        logic [7:0] rsp_model;
        logic [9:0] w_cur, w_nxt;
        logic [7:0] mb;
        bit         chain, prev_chain, tog;
        int         lows, dones;

        vt[0] = '{10'h0A5, 8'hFF, 12, 32'h0000_00A5, 0, 8'h00};
        vt[1] = '{10'h2C3, 8'h00, 12, 32'h0000_06C3, 0, 8'h00};
        vt[2] = '{10'h300, 8'h5A, 21, 32'h000E_0000, 1, 8'h5A};
        vt[3] = '{10'h1FF, 8'h00, 12, 32'h0000_01FF, 0, 8'h5A};
        vt[4] = '{10'h3C3, 8'hA5, 21, 32'h000F_8600, 1, 8'hA5};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; MISO = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ss_n", SS_n, 1);
        chk("reset_mosi", MOSI, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);

        foreach (vt[i]) begin
            run_frame(vt[i].w, vt[i].mb, 0, 0, 10'h0, r);
            chk("vec_timeout", 32'(r.to), 0);
            chk("vec_low", r.low, vt[i].low);
            chk("vec_mosi", r.seq, vt[i].seq);
            chk("vec_done", r.dones, 1);
            chk("vec_rspv", r.rsps, vt[i].rv);
            chk("vec_rsp_not_with_done", r.bad, 0);
            chk("vec_rsp_data", r.rsp, vt[i].rsp);
            @(negedge clk);
            chk("vec_idle_ready", cmd_ready, 1);
            chk("vec_idle_busy", busy, 0);
        end
        rsp_model = 8'hA5;

        // Back-to-back: second command waits with cmd_valid high, accepted right after DONE.
        run_frame(10'h0A5, 8'h00, 0, 1, 10'h2C3, r);
        check_frame("b2b_first", r, 10'h0A5, rsp_model);
        run_frame(10'h2C3, 8'h00, 0, 0, 10'h0, r);
        check_frame("b2b_second", r, 10'h2C3, rsp_model);
        chk("b2b_ss_high_gap", r.prehigh, EXP_HIGH);

        // cmd_valid toggling while busy must not start extra frames.
        run_frame(10'h311, 8'h3C, 1, 0, 10'h0, r);
        rsp_model = 8'h3C;
        check_frame("toggle", r, 10'h311, rsp_model);
        lows = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!SS_n) lows++;
        end
        chk("toggle_no_extra_frame", lows, 0);

        prev_chain = 0;
        w_cur = 10'($urandom);
        for (int i = 0; i < 24; i++) begin
            chain = 1'($urandom);
            tog   = 1'($urandom) && !chain;
            w_nxt = 10'($urandom);
            mb    = 8'($urandom);
            run_frame(w_cur, mb, tog, chain, w_nxt, r);
            if (w_cur[9:8] == 2'b11) rsp_model = mb;
            check_frame("rand", r, w_cur, rsp_model);
            if (prev_chain) chk("rand_ss_high_gap", r.prehigh, EXP_HIGH);
            if (!chain) repeat ($urandom_range(1, 4)) @(negedge clk);
            prev_chain = chain;
            w_cur = w_nxt;
        end
        if (prev_chain) begin
            cmd_valid = 1'b0;
            repeat (6) @(negedge clk);
        end

        // Reset asserted mid-SHIFT: frame abandoned, SS_n released at once, no done.
        cmd_data = 10'h3FF; cmd_valid = 1'b1;
        lows = 0;
        for (int c = 0; c < 20 && lows < 5; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (!SS_n) lows++;
        end
        chk("midreset_reached_shift", lows, 5);
        rst_n = 1'b0;
        #1;
        chk("midreset_ss_n", SS_n, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0; dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!SS_n) lows++;
            if (done || rsp_valid) dones++;
        end
        chk("midreset_no_low", lows, 0);
        chk("midreset_no_done", dones, 0);
        chk("midreset_rsp_data", rsp_data, 0);
        chk("midreset_ready", cmd_ready, 1);

        run_frame(10'h0A5, 8'h00, 0, 0, 10'h0, r);
        check_frame("after_reset", r, 10'h0A5, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
